// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM elastic stage: default widths, the stage entry record
// and the data-cache control encodings carried opaquely through the stage.
package ex_mem_pkg;

    localparam int unsigned DATA_W_DEFAULT     = 32;
    localparam int unsigned REG_ADDR_W_DEFAULT = 5;
    localparam int unsigned DC_CTRL_W_DEFAULT  = 4;

    typedef enum logic [DC_CTRL_W_DEFAULT-1:0] {
        DcNone = 4'h0,
        DcLb   = 4'h1,
        DcLh   = 4'h2,
        DcLw   = 4'h3,
        DcLbu  = 4'h4,
        DcLhu  = 4'h5,
        DcSb   = 4'h9,
        DcSh   = 4'ha,
        DcSw   = 4'hb
    } dc_ctrl_e;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0]     data;
        logic [DATA_W_DEFAULT-1:0]     rs2;
        logic                          we;
        logic                          csl;
        logic [DC_CTRL_W_DEFAULT-1:0]  dc_ctrl;
        logic [REG_ADDR_W_DEFAULT-1:0] wb_addr;
    } stage_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Looks up one decode source register across the head and skid entries; the younger skid
// entry wins, and a matching load reports a hazard instead of a forward.
module fwd_match
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  head_valid,
    input  logic                  head_we,
    input  logic                  head_csl,
    input  logic [REG_ADDR_W-1:0] head_addr,
    input  logic [DATA_W-1:0]     head_data,
    input  logic                  skid_valid,
    input  logic                  skid_we,
    input  logic                  skid_csl,
    input  logic [REG_ADDR_W-1:0] skid_addr,
    input  logic [DATA_W-1:0]     skid_data,
    output logic                  hit,
    output logic [DATA_W-1:0]     data,
    output logic                  load
);

    logic head_cand;
    logic skid_cand;

    assign head_cand = head_valid & head_we & (head_addr == src) & (src != '0);
    assign skid_cand = skid_valid & skid_we & (skid_addr == src) & (src != '0);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        load = 1'b0;
        if (skid_cand) begin
            hit  = ~skid_csl;
            data = skid_csl ? '0 : skid_data;
            load = skid_csl;
        end else if (head_cand) begin
            hit  = ~head_csl;
            data = head_csl ? '0 : head_data;
            load = head_csl;
        end
    end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// Elastic EX->MEM stage: valid/ready on both sides, optional 2-entry skid buffer, synchronous
// flush, and forwarding / load-use detection from the in-flight entries.
module ex_mem_stage_buf
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int unsigned DC_CTRL_W  = DC_CTRL_W_DEFAULT,
    parameter bit          SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W-1:0]     rs2_in,
    input  logic                  we_in,
    input  logic                  csl_in,
    input  logic [DC_CTRL_W-1:0]  dc_ctrl_in,
    input  logic [REG_ADDR_W-1:0] wb_addr_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     data_out,
    output logic [DATA_W-1:0]     rs2_out,
    output logic [DC_CTRL_W-1:0]  dc_ctrl_out,
    output logic [REG_ADDR_W-1:0] wb_addr_out,
    output logic                  we_out,
    output logic                  csl_out,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_W-1:0]     fwd1_data,
    output logic [DATA_W-1:0]     fwd2_data,
    output logic                  load_use
);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     rs2;
        logic                  we;
        logic                  csl;
        logic [DC_CTRL_W-1:0]  dc_ctrl;
        logic [REG_ADDR_W-1:0] wb_addr;
    } entry_t;

    entry_t head_q, head_d, skid_q, skid_d, in_entry;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   rdy_q;
    logic   accept, retire;
    logic   load1, load2;

    // x0 writes are squashed on entry so they never forward or retire as a write.
    always_comb begin
        in_entry.data    = data_in;
        in_entry.rs2     = rs2_in;
        in_entry.we      = we_in & (wb_addr_in != '0);
        in_entry.csl     = csl_in;
        in_entry.dc_ctrl = dc_ctrl_in;
        in_entry.wb_addr = wb_addr_in;
    end

    assign in_ready  = SKID_EN ? rdy_q : (rdy_q & (~head_valid_q | out_ready));
    assign out_valid = head_valid_q;
    assign accept    = in_valid & in_ready;
    assign retire    = head_valid_q & out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (SKID_EN) begin
            if (retire) begin
                // With the skid full in_ready is low, so no accept competes here.
                if (skid_valid_q) begin
                    head_d       = skid_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    head_d = in_entry;
                end else begin
                    head_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!head_valid_q) begin
                    head_d       = in_entry;
                    head_valid_d = 1'b1;
                end else begin
                    skid_d       = in_entry;
                    skid_valid_d = 1'b1;
                end
            end
        end else begin
            if (accept) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else if (retire) begin
                head_valid_d = 1'b0;
            end
        end
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= ~skid_valid_d;
        end
    end

    assign data_out    = head_q.data;
    assign rs2_out     = head_q.rs2;
    assign dc_ctrl_out = head_q.dc_ctrl;
    assign wb_addr_out = head_q.wb_addr;
    assign we_out      = head_valid_q & head_q.we;
    assign csl_out     = head_valid_q & head_q.csl;

    fwd_match #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd1 (
        .src        (dec_rs1),
        .head_valid (head_valid_q),
        .head_we    (head_q.we),
        .head_csl   (head_q.csl),
        .head_addr  (head_q.wb_addr),
        .head_data  (head_q.data),
        .skid_valid (skid_valid_q),
        .skid_we    (skid_q.we),
        .skid_csl   (skid_q.csl),
        .skid_addr  (skid_q.wb_addr),
        .skid_data  (skid_q.data),
        .hit        (fwd1_hit),
        .data       (fwd1_data),
        .load       (load1)
    );

    fwd_match #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd2 (
        .src        (dec_rs2),
        .head_valid (head_valid_q),
        .head_we    (head_q.we),
        .head_csl   (head_q.csl),
        .head_addr  (head_q.wb_addr),
        .head_data  (head_q.data),
        .skid_valid (skid_valid_q),
        .skid_we    (skid_q.we),
        .skid_csl   (skid_q.csl),
        .skid_addr  (skid_q.wb_addr),
        .skid_data  (skid_q.data),
        .hit        (fwd2_hit),
        .data       (fwd2_data),
        .load       (load2)
    );

    assign load_use = load1 | load2;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Scoreboard bench for ex_mem_stage_buf: a queue of in-flight instructions is the reference
// model; a negedge monitor pops and compares every retired head.
module tb_ex_mem_stage_buf;

    typedef struct {
        logic [31:0] data;
        logic [31:0] rs2;
        logic        we;
        logic        csl;
        logic [3:0]  ctrl;
        logic [4:0]  addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] data_in = '0, rs2_in = '0;
    logic        we_in = 1'b0, csl_in = 1'b0;
    logic [3:0]  dc_ctrl_in = '0;
    logic [4:0]  wb_addr_in = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] data_out, rs2_out;
    logic [3:0]  dc_ctrl_out;
    logic [4:0]  wb_addr_out;
    logic        we_out, csl_out;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0;
    logic        fwd1_hit, fwd2_hit, load_use;
    logic [31:0] fwd1_data, fwd2_data;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];          // in-flight instructions, oldest first
    logic in_rst = 1'b1; // reset was applied at the most recent edge

    ex_mem_stage_buf dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .rs2_in      (rs2_in),
        .we_in       (we_in),
        .csl_in      (csl_in),
        .dc_ctrl_in  (dc_ctrl_in),
        .wb_addr_in  (wb_addr_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .rs2_out     (rs2_out),
        .dc_ctrl_out (dc_ctrl_out),
        .wb_addr_out (wb_addr_out),
        .we_out      (we_out),
        .csl_out     (csl_out),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .fwd1_hit    (fwd1_hit),
        .fwd2_hit    (fwd2_hit),
        .fwd1_data   (fwd1_data),
        .fwd2_data   (fwd2_data),
        .load_use    (load_use)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest in-flight writer of rs decides: ALU result forwards, load raises a hazard.
    task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d,
                             output logic ld);
        hit = 1'b0;
        d   = '0;
        ld  = 1'b0;
        if (rs != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].we && q[i].addr == rs) begin
                    if (q[i].csl) ld = 1'b1;
                    else begin
                        hit = 1'b1;
                        d   = q[i].data;
                    end
                    break;
                end
            end
        end
    endtask

    function automatic ent_t mk(input logic [31:0] d, input logic we, input logic csl,
                                input logic [4:0] a);
        ent_t e;
        e.data = d;
        e.rs2  = ~d;
        e.we   = we;
        e.csl  = csl;
        e.ctrl = csl ? 4'h3 : 4'h0;
        e.addr = a;
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e.data = $urandom;
        e.rs2  = $urandom;
        e.we   = 1'($urandom_range(0, 1));
        e.csl  = 1'($urandom_range(0, 1));
        e.ctrl = 4'($urandom_range(0, 15));
        e.addr = 5'($urandom_range(0, 7));
        return e;
    endfunction

    task automatic step(input logic r, input logic iv, input ent_t e, input logic fl,
                        input logic ordy, input logic [4:0] r1, input logic [4:0] r2);
        logic        exp_rdy, h1, h2, l1, l2;
        logic [31:0] d1, d2;
        @(posedge clk);
        #1;
        rst = r; in_valid = iv; flush = fl; out_ready = ordy;
        data_in = e.data; rs2_in = e.rs2; we_in = e.we; csl_in = e.csl;
        dc_ctrl_in = e.ctrl; wb_addr_in = e.addr;
        dec_rs1 = r1; dec_rs2 = r2;
        #1;
        exp_rdy = !in_rst && (q.size() < 2);
        if (in_rst) begin
            chk("rst in_ready", {31'd0, in_ready}, 0);
            chk("rst out_valid", {31'd0, out_valid}, 0);
            chk("rst strobes", {30'd0, we_out, csl_out}, 0);
            chk("rst data_out", data_out, 0);
            chk("rst rs2_out", rs2_out, 0);
            chk("rst ctrl/addr", {23'd0, dc_ctrl_out, wb_addr_out}, 0);
            chk("rst fwd", {29'd0, fwd1_hit, fwd2_hit, load_use}, 0);
        end else begin
            model_fwd(r1, h1, d1, l1);
            model_fwd(r2, h2, d2, l2);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, h1});
            chk("fwd1_data", fwd1_data, d1);
            chk("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, h2});
            chk("fwd2_data", fwd2_data, d2);
            chk("load_use", {31'd0, load_use}, {31'd0, l1 | l2});
        end
        #6;
        if (r || fl) q.delete();
        else if (iv && exp_rdy) q.push_back(e);
        in_rst = r;
    endtask

    // Monitor: compares the head against the oldest expected instruction on every retire.
    always @(negedge clk) begin
        ent_t e;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (!out_valid) chk("idle strobes", {30'd0, we_out, csl_out}, 0);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL retire: unexpected entry data %h, expected none", data_out);
            end else begin
                e = q.pop_front();
                chk("data_out", data_out, e.data);
                chk("rs2_out", rs2_out, e.rs2);
                chk("we_out", {31'd0, we_out}, {31'd0, e.we && e.addr != 5'd0});
                chk("csl_out", {31'd0, csl_out}, {31'd0, e.csl});
                chk("dc_ctrl_out", {28'd0, dc_ctrl_out}, {28'd0, e.ctrl});
                chk("wb_addr_out", {27'd0, wb_addr_out}, {27'd0, e.addr});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t z;
        z = mk(32'h0, 1'b0, 1'b0, 5'd0);

        // Reset, then streaming with out_ready high.
        step(1, 0, z, 0, 0, 0, 0);
        step(1, 0, z, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, mk(32'h10 + i, 1, 0, 5'd3), 0, 1, 3, 0);
        step(0, 0, z, 0, 1, 3, 0);
        step(0, 0, z, 0, 1, 0, 0);

        // Stall: A in head, B in skid, C waits.
        step(0, 1, mk(32'hA, 1, 0, 5'd1), 0, 0, 1, 2);
        step(0, 1, mk(32'hB, 1, 0, 5'd2), 0, 0, 1, 2);
        step(0, 1, mk(32'hC, 1, 0, 5'd3), 0, 0, 1, 2);
        chk("stall in_ready", {31'd0, in_ready}, 0);
        step(0, 1, mk(32'hC, 1, 0, 5'd3), 0, 1, 3, 2);
        for (int i = 0; i < 4; i++) step(0, 0, z, 0, 1, 0, 0);

        // Flush with both entries full and an entry offered.
        step(0, 1, mk(32'hD1, 1, 0, 5'd4), 0, 0, 0, 0);
        step(0, 1, mk(32'hD2, 1, 0, 5'd4), 0, 0, 0, 0);
        step(0, 1, mk(32'hD3, 1, 0, 5'd4), 1, 0, 0, 0);
        step(0, 0, z, 0, 1, 0, 0);
        chk("flush out_valid", {31'd0, out_valid}, 0);
        chk("flush in_ready", {31'd0, in_ready}, 1);

        // Forwarding: skid entry is younger than head.
        step(0, 1, mk(32'hAAAA, 1, 0, 5'd5), 0, 0, 5, 0);
        step(0, 1, mk(32'hBBBB, 1, 0, 5'd5), 0, 0, 5, 0);
        step(0, 0, z, 0, 0, 5, 0);
        chk("fwd young hit", {31'd0, fwd1_hit}, 1);
        chk("fwd young data", fwd1_data, 32'hBBBB);
        step(0, 0, z, 1, 0, 0, 0);
        step(0, 1, mk(32'h55, 1, 0, 5'd0), 0, 0, 0, 0);
        step(0, 0, z, 0, 0, 0, 0);
        chk("x0 no fwd", {31'd0, fwd2_hit}, 0);

        // Load-use, then overridden by a younger ALU write.
        step(0, 0, z, 1, 0, 0, 0);
        step(0, 1, mk(32'h700, 1, 1, 5'd7), 0, 0, 0, 7);
        step(0, 0, z, 0, 0, 0, 7);
        chk("load_use raised", {31'd0, load_use}, 1);
        step(0, 1, mk(32'h777, 1, 0, 5'd7), 0, 0, 0, 7);
        step(0, 0, z, 0, 0, 0, 7);
        chk("load_use cleared", {31'd0, load_use}, 0);
        chk("alu over load", {31'd0, fwd2_hit}, 1);

        // Reset with both entries full.
        step(1, 1, mk(32'h99, 1, 0, 5'd2), 0, 0, 7, 7);
        step(0, 0, z, 0, 0, 7, 7);
        chk("mid rst out_valid", {31'd0, out_valid}, 0);
        chk("mid rst in_ready", {31'd0, in_ready}, 0);
        step(0, 0, z, 0, 0, 0, 0);
        chk("post rst in_ready", {31'd0, in_ready}, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), rnd(),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 8; i++) step(0, 0, z, 0, 1, 0, 0);
        chk("drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
